// File: rtl/rf_fill_scheduler_pkg.sv
// Shared types and encodings for the RF fill scheduler.
//   state_e  : FSM states (IDLE/ISSUE/DRAIN/DONE, 2-bit)
//   CLS_*    : request class encoding (actv=0, wgt=1)
//   BUF*     : RF buffer encoding (rf1=0, rf2=1)
//   grant_t  : latched grant record {class, buffer}
package rf_fill_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic CLS_ACTV = 1'b0;
    localparam logic CLS_WGT  = 1'b1;

    localparam logic BUF1 = 1'b0;
    localparam logic BUF2 = 1'b1;

    typedef struct packed {
        logic cls;
        logic buf_sel;
    } grant_t;

    // Flat request index {cls, buf}: actv1=0, actv2=1, wgt1=2, wgt2=3.
    function automatic logic [1:0] req_idx(input grant_t g);
        return {g.cls, g.buf_sel};
    endfunction

endpackage

// File: rtl/rf_fill_scheduler_rr_arb2.sv
// Two-way round-robin class arbiter (actv vs wgt).
// Ports:
//   clk, reset     : clock, async active-high reset (pointer -> actv)
//   req_i[1:0]     : bit0 = actv class request, bit1 = wgt class request
//   en_i           : arbitration allowed this cycle
//   grant_valid_o  : a grant is issued this cycle (combinational)
//   grant_cls_o    : winning class (combinational)
module rr_arb2
    import rf_fill_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       grant_valid_o,
    output logic       grant_cls_o
);

    logic ptr_q;
    logic ptr_d;

    // Lone requester wins; on contention the pointer decides.
    always_comb begin
        grant_valid_o = en_i && (req_i != 2'b00);
        grant_cls_o   = ptr_q;
        if (req_i == 2'b01) begin
            grant_cls_o = CLS_ACTV;
        end else if (req_i == 2'b10) begin
            grant_cls_o = CLS_WGT;
        end
        ptr_d = ptr_q ^ grant_valid_o;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= CLS_ACTV;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_fill_scheduler.sv
// Shares one GBF read port between the four PE-array RF refill requests.
// Each grant issues a DEPTH-beat GBF read burst, steers the returned words
// into the actv or wgt RF write path, then pulses the matching send_finish.
// Optional feature macro: RF_FILL_PERF_CNT_EN (builds the stall counter).
// Ports:
//   clk, reset               : clock, async active-high reset
//   finish                   : block new grants
//   *_need_data              : level refill requests
//   actv/wgt_base_addr       : region base, sampled at grant
//   gbf_rd_en/addr/data      : GBF read port (1-cycle read latency)
//   actv_*/wgt_* w_en/buf/addr/data : RF write paths
//   *_send_finish            : one-cycle burst-done pulses
//   actv/wgt_data_avail      : class has at least one valid RF
//   busy, stall_cnt          : status and perf counter
module rf_fill_scheduler
    import rf_fill_scheduler_pkg::*;
#(
    parameter int unsigned ACTV_ADDR_BITWIDTH = 2,
    parameter int unsigned ACTV_DEPTH         = 4,
    parameter int unsigned WGT_ADDR_BITWIDTH  = 2,
    parameter int unsigned WGT_DEPTH          = 4,
    parameter int unsigned GBF_ADDR_BITWIDTH  = 10,
    parameter int unsigned GBF_DATA_BITWIDTH  = 512
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          finish,
    input  logic                          actv_rf1_need_data,
    input  logic                          actv_rf2_need_data,
    input  logic                          wgt_rf1_need_data,
    input  logic                          wgt_rf2_need_data,
    input  logic [GBF_ADDR_BITWIDTH-1:0]  actv_base_addr,
    input  logic [GBF_ADDR_BITWIDTH-1:0]  wgt_base_addr,
    output logic                          gbf_rd_en,
    output logic [GBF_ADDR_BITWIDTH-1:0]  gbf_rd_addr,
    input  logic [GBF_DATA_BITWIDTH-1:0]  gbf_rd_data,
    output logic                          actv_w_en,
    output logic                          actv_w_buf,
    output logic [ACTV_ADDR_BITWIDTH-1:0] actv_w_addr,
    output logic [GBF_DATA_BITWIDTH-1:0]  actv_data,
    output logic                          wgt_w_en,
    output logic                          wgt_w_buf,
    output logic [WGT_ADDR_BITWIDTH-1:0]  wgt_w_addr,
    output logic [GBF_DATA_BITWIDTH-1:0]  wgt_data,
    output logic                          actv_buf1_send_finish,
    output logic                          actv_buf2_send_finish,
    output logic                          wgt_buf1_send_finish,
    output logic                          wgt_buf2_send_finish,
    output logic                          actv_data_avail,
    output logic                          wgt_data_avail,
    output logic                          busy,
    output logic [31:0]                   stall_cnt
);

    localparam int unsigned BEAT_W = (ACTV_ADDR_BITWIDTH > WGT_ADDR_BITWIDTH) ?
                                     ACTV_ADDR_BITWIDTH : WGT_ADDR_BITWIDTH;
    localparam logic [BEAT_W-1:0] ACTV_LAST = BEAT_W'(ACTV_DEPTH - 1);
    localparam logic [BEAT_W-1:0] WGT_LAST  = BEAT_W'(WGT_DEPTH - 1);
    localparam logic [GBF_ADDR_BITWIDTH-1:0] ACTV_STEP = GBF_ADDR_BITWIDTH'(ACTV_DEPTH);
    localparam logic [GBF_ADDR_BITWIDTH-1:0] WGT_STEP  = GBF_ADDR_BITWIDTH'(WGT_DEPTH);

    state_e                         state_q, state_d;
    logic [BEAT_W-1:0]              beat_q, beat_d;
    logic [BEAT_W-1:0]              beat_nxt;
    logic [BEAT_W-1:0]              beat_last;
    grant_t                         gnt_q, gnt_d;
    logic [GBF_ADDR_BITWIDTH-1:0]   burst_base_q, burst_base_d;
    logic [GBF_ADDR_BITWIDTH-1:0]   actv_off_q, actv_off_d;
    logic [GBF_ADDR_BITWIDTH-1:0]   wgt_off_q, wgt_off_d;
    logic [3:0]                     need;
    logic [3:0]                     need_q;
    logic [3:0]                     rise;
    logic [3:0]                     elig;
    logic [3:0]                     served_q, served_d;
    logic [3:0]                     valid_q, valid_d;
    logic [3:0]                     set_mask;
    logic [3:0]                     send_fin_q, send_fin_d;
    logic                           rd_en_q, rd_en_d;
    logic [GBF_ADDR_BITWIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                           actv_w_en_q, actv_w_en_d;
    logic                           actv_w_buf_q, actv_w_buf_d;
    logic [ACTV_ADDR_BITWIDTH-1:0]  actv_w_addr_q, actv_w_addr_d;
    logic                           wgt_w_en_q, wgt_w_en_d;
    logic                           wgt_w_buf_q, wgt_w_buf_d;
    logic [WGT_ADDR_BITWIDTH-1:0]   wgt_w_addr_q, wgt_w_addr_d;
    logic                           actv_avail_q, actv_avail_d;
    logic                           wgt_avail_q, wgt_avail_d;
    logic                           busy_q, busy_d;
    logic                           arb_valid;
    logic                           arb_cls;
    logic                           grant_buf;

    // Request bookkeeping: eligible = needed and not yet served.
    assign need = {wgt_rf2_need_data, wgt_rf1_need_data,
                   actv_rf2_need_data, actv_rf1_need_data};
    assign elig = need & ~served_q;
    assign rise = need & ~need_q;

    rr_arb2 u_arb (
        .clk           (clk),
        .reset         (reset),
        .req_i         ({|elig[3:2], |elig[1:0]}),
        .en_i          ((state_q == ST_IDLE) && !finish),
        .grant_valid_o (arb_valid),
        .grant_cls_o   (arb_cls)
    );

    // rf1 beats rf2 inside the winning class.
    assign grant_buf = (arb_cls == CLS_ACTV) ? (elig[0] ? BUF1 : BUF2)
                                             : (elig[2] ? BUF1 : BUF2);

    assign beat_last = (gnt_q.cls == CLS_WGT) ? WGT_LAST : ACTV_LAST;
    assign beat_nxt  = beat_q + BEAT_W'(1);

    // FSM next-state, read issue and burst-completion bookkeeping.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        gnt_d        = gnt_q;
        burst_base_d = burst_base_q;
        actv_off_d   = actv_off_q;
        wgt_off_d    = wgt_off_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = '0;
        send_fin_d   = '0;
        set_mask     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d.cls     = arb_cls;
                    gnt_d.buf_sel = grant_buf;
                    burst_base_d  = (arb_cls == CLS_WGT) ? (wgt_base_addr + wgt_off_q)
                                                         : (actv_base_addr + actv_off_q);
                    beat_d        = '0;
                    rd_en_d       = 1'b1;
                    rd_addr_d     = burst_base_d;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (beat_q == beat_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    beat_d    = beat_nxt;
                    rd_en_d   = 1'b1;
                    rd_addr_d = burst_base_q + GBF_ADDR_BITWIDTH'(beat_nxt);
                end
            end
            ST_DRAIN: begin
                send_fin_d[req_idx(gnt_q)] = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                set_mask[req_idx(gnt_q)] = 1'b1;
                if (gnt_q.cls == CLS_WGT) begin
                    wgt_off_d = wgt_off_q + WGT_STEP;
                end else begin
                    actv_off_d = actv_off_q + ACTV_STEP;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write path trails the read strobe by the GBF read latency.
    always_comb begin
        actv_w_en_d   = rd_en_q && (gnt_q.cls == CLS_ACTV);
        actv_w_buf_d  = actv_w_en_d ? gnt_q.buf_sel : 1'b0;
        actv_w_addr_d = actv_w_en_d ? ACTV_ADDR_BITWIDTH'(beat_q) : '0;
        wgt_w_en_d    = rd_en_q && (gnt_q.cls == CLS_WGT);
        wgt_w_buf_d   = wgt_w_en_d ? gnt_q.buf_sel : 1'b0;
        wgt_w_addr_d  = wgt_w_en_d ? WGT_ADDR_BITWIDTH'(beat_q) : '0;
    end

    // Served clears once need drops; valid clears on a new request edge.
    always_comb begin
        served_d     = (served_q | set_mask) & need;
        valid_d      = (valid_q & ~rise) | set_mask;
        actv_avail_d = |valid_d[1:0];
        wgt_avail_d  = |valid_d[3:2];
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            beat_q        <= '0;
            gnt_q         <= '0;
            burst_base_q  <= '0;
            actv_off_q    <= '0;
            wgt_off_q     <= '0;
            need_q        <= '0;
            served_q      <= '0;
            valid_q       <= '0;
            send_fin_q    <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            actv_w_en_q   <= 1'b0;
            actv_w_buf_q  <= 1'b0;
            actv_w_addr_q <= '0;
            wgt_w_en_q    <= 1'b0;
            wgt_w_buf_q   <= 1'b0;
            wgt_w_addr_q  <= '0;
            actv_avail_q  <= 1'b0;
            wgt_avail_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            gnt_q         <= gnt_d;
            burst_base_q  <= burst_base_d;
            actv_off_q    <= actv_off_d;
            wgt_off_q     <= wgt_off_d;
            need_q        <= need;
            served_q      <= served_d;
            valid_q       <= valid_d;
            send_fin_q    <= send_fin_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            actv_w_en_q   <= actv_w_en_d;
            actv_w_buf_q  <= actv_w_buf_d;
            actv_w_addr_q <= actv_w_addr_d;
            wgt_w_en_q    <= wgt_w_en_d;
            wgt_w_buf_q   <= wgt_w_buf_d;
            wgt_w_addr_q  <= wgt_w_addr_d;
            actv_avail_q  <= actv_avail_d;
            wgt_avail_q   <= wgt_avail_d;
            busy_q        <= busy_d;
        end
    end

    assign gbf_rd_en             = rd_en_q;
    assign gbf_rd_addr           = rd_addr_q;
    assign actv_w_en             = actv_w_en_q;
    assign actv_w_buf            = actv_w_buf_q;
    assign actv_w_addr           = actv_w_addr_q;
    assign wgt_w_en              = wgt_w_en_q;
    assign wgt_w_buf             = wgt_w_buf_q;
    assign wgt_w_addr            = wgt_w_addr_q;
    // Read data arrives unregistered; gate it so idle write data stays 0.
    assign actv_data             = actv_w_en_q ? gbf_rd_data : '0;
    assign wgt_data              = wgt_w_en_q  ? gbf_rd_data : '0;
    assign actv_buf1_send_finish = send_fin_q[0];
    assign actv_buf2_send_finish = send_fin_q[1];
    assign wgt_buf1_send_finish  = send_fin_q[2];
    assign wgt_buf2_send_finish  = send_fin_q[3];
    assign actv_data_avail       = actv_avail_q;
    assign wgt_data_avail        = wgt_avail_q;
    assign busy                  = busy_q;

`ifdef RF_FILL_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles where a request waits on a busy scheduler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (busy_q && (elig != 4'b0000) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rf_fill_scheduler.sv
// Directed self-checking bench for rf_fill_scheduler (default parameters).
module tb_rf_fill_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic         finish;
    logic         actv_rf1_need_data, actv_rf2_need_data;
    logic         wgt_rf1_need_data, wgt_rf2_need_data;
    logic [9:0]   actv_base_addr, wgt_base_addr;
    logic         gbf_rd_en;
    logic [9:0]   gbf_rd_addr;
    logic [511:0] gbf_rd_data;
    logic         actv_w_en, actv_w_buf;
    logic [1:0]   actv_w_addr;
    logic [511:0] actv_data;
    logic         wgt_w_en, wgt_w_buf;
    logic [1:0]   wgt_w_addr;
    logic [511:0] wgt_data;
    logic         actv_buf1_send_finish, actv_buf2_send_finish;
    logic         wgt_buf1_send_finish, wgt_buf2_send_finish;
    logic         actv_data_avail, wgt_data_avail;
    logic         busy;
    logic [31:0]  stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    rf_fill_scheduler dut (
        .clk                   (clk),
        .reset                 (reset),
        .finish                (finish),
        .actv_rf1_need_data    (actv_rf1_need_data),
        .actv_rf2_need_data    (actv_rf2_need_data),
        .wgt_rf1_need_data     (wgt_rf1_need_data),
        .wgt_rf2_need_data     (wgt_rf2_need_data),
        .actv_base_addr        (actv_base_addr),
        .wgt_base_addr         (wgt_base_addr),
        .gbf_rd_en             (gbf_rd_en),
        .gbf_rd_addr           (gbf_rd_addr),
        .gbf_rd_data           (gbf_rd_data),
        .actv_w_en             (actv_w_en),
        .actv_w_buf            (actv_w_buf),
        .actv_w_addr           (actv_w_addr),
        .actv_data             (actv_data),
        .wgt_w_en              (wgt_w_en),
        .wgt_w_buf             (wgt_w_buf),
        .wgt_w_addr            (wgt_w_addr),
        .wgt_data              (wgt_data),
        .actv_buf1_send_finish (actv_buf1_send_finish),
        .actv_buf2_send_finish (actv_buf2_send_finish),
        .wgt_buf1_send_finish  (wgt_buf1_send_finish),
        .wgt_buf2_send_finish  (wgt_buf2_send_finish),
        .actv_data_avail       (actv_data_avail),
        .wgt_data_avail        (wgt_data_avail),
        .busy                  (busy),
        .stall_cnt             (stall_cnt)
    );

    always #5 clk = ~clk;

    // GBF word content is a function of its address.
    function automatic logic [511:0] mk(input logic [9:0] a);
        return {16{22'h2B5A5A, a}};
    endfunction

    // GBF model with one cycle of read latency.
    always @(posedge clk) begin
        gbf_rd_data <= gbf_rd_en ? mk(gbf_rd_addr) : '0;
    end

    function automatic logic [3:0] sf_vec();
        return {wgt_buf2_send_finish, wgt_buf1_send_finish,
                actv_buf2_send_finish, actv_buf1_send_finish};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        finish = 1'b0;
        actv_rf1_need_data = 1'b0;
        actv_rf2_need_data = 1'b0;
        wgt_rf1_need_data  = 1'b0;
        wgt_rf2_need_data  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        finish = 1'b0;
        actv_rf1_need_data = 1'b0;
        actv_rf2_need_data = 1'b0;
        wgt_rf1_need_data  = 1'b0;
        wgt_rf2_need_data  = 1'b0;
        actv_base_addr = 10'h100;
        wgt_base_addr  = 10'h200;
        tick();
        tick();
        n_tests++;
        if (gbf_rd_en !== 1'b0 || gbf_rd_addr !== 10'h000) begin
            n_fail++; $display("FAIL reset_rd: got en=%0b addr=%0h expected en=0 addr=0", gbf_rd_en, gbf_rd_addr);
        end
        n_tests++;
        if (actv_w_en !== 1'b0 || wgt_w_en !== 1'b0 || actv_data !== '0 || wgt_data !== '0) begin
            n_fail++; $display("FAIL reset_wr: got actv_w_en=%0b wgt_w_en=%0b expected 0/0 with zero data", actv_w_en, wgt_w_en);
        end
        n_tests++;
        if (sf_vec() !== 4'b0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: got sf=%0b busy=%0b expected 0000/0", sf_vec(), busy);
        end
        n_tests++;
        if (actv_data_avail !== 1'b0 || wgt_data_avail !== 1'b0 || stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_avail: got avail=%0b%0b stall=%0d expected 00/0", actv_data_avail, wgt_data_avail, stall_cnt);
        end
        reset = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0 || gbf_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got busy=%0b rd_en=%0b expected 0/0", busy, gbf_rd_en);
        end
    endtask

    // Single actv rf1 burst from base 0x100, cycle-by-cycle.
    task automatic test_single_burst();
        logic       exp_rd, exp_w, exp_f;
        logic [9:0] exp_addr, wa;
        do_reset();
        actv_base_addr = 10'h100;
        actv_rf1_need_data = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp_rd   = (c <= 4);
            exp_addr = exp_rd ? 10'(256 + c - 1) : 10'h000;
            n_tests++;
            if (gbf_rd_en !== exp_rd || gbf_rd_addr !== exp_addr) begin
                n_fail++; $display("FAIL single_rd c=%0d: got en=%0b addr=%0h expected en=%0b addr=%0h", c, gbf_rd_en, gbf_rd_addr, exp_rd, exp_addr);
            end
            exp_w = (c >= 2 && c <= 5);
            n_tests++;
            if (actv_w_en !== exp_w || wgt_w_en !== 1'b0) begin
                n_fail++; $display("FAIL single_wen c=%0d: got actv=%0b wgt=%0b expected actv=%0b wgt=0", c, actv_w_en, wgt_w_en, exp_w);
            end
            if (exp_w) begin
                wa = 10'(256 + c - 2);
                n_tests++;
                if (actv_w_addr !== 2'(c - 2) || actv_w_buf !== 1'b0 || actv_data !== mk(wa)) begin
                    n_fail++; $display("FAIL single_wdata c=%0d: got waddr=%0d buf=%0b data_lo=%0h expected waddr=%0d buf=0 data_lo=%0h", c, actv_w_addr, actv_w_buf, actv_data[31:0], c - 2, mk(wa) & 512'hFFFF_FFFF);
                end
            end
            exp_f = (c == 6);
            n_tests++;
            if (sf_vec() !== {3'b000, exp_f}) begin
                n_fail++; $display("FAIL single_finish c=%0d: got sf=%0b expected %0b", c, sf_vec(), {3'b000, exp_f});
            end
        end
        n_tests++;
        if (actv_data_avail !== 1'b1 || wgt_data_avail !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_avail: got actv=%0b wgt=%0b busy=%0b expected 1/0/0", actv_data_avail, wgt_data_avail, busy);
        end
    endtask

    // All four requests at once: actv1, wgt1, actv2, wgt2, 7 cycles apart.
    task automatic test_back_to_back();
        logic [3:0] exp_sf;
        do_reset();
        actv_base_addr = 10'h100;
        wgt_base_addr  = 10'h200;
        actv_rf1_need_data = 1'b1;
        actv_rf2_need_data = 1'b1;
        wgt_rf1_need_data  = 1'b1;
        wgt_rf2_need_data  = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            case (c)
                6:       exp_sf = 4'b0001;
                13:      exp_sf = 4'b0100;
                20:      exp_sf = 4'b0010;
                27:      exp_sf = 4'b1000;
                default: exp_sf = 4'b0000;
            endcase
            n_tests++;
            if (sf_vec() !== exp_sf) begin
                n_fail++; $display("FAIL b2b_finish c=%0d: got %0b expected %0b", c, sf_vec(), exp_sf);
            end
            if (c == 1 || c == 8 || c == 15 || c == 22) begin
                n_tests++;
                if (gbf_rd_en !== 1'b1 ||
                    gbf_rd_addr !== ((c == 1) ? 10'h100 : (c == 8) ? 10'h200 : (c == 15) ? 10'h104 : 10'h204)) begin
                    n_fail++; $display("FAIL b2b_start c=%0d: got en=%0b addr=%0h", c, gbf_rd_en, gbf_rd_addr);
                end
            end
            if (c == 9) begin
                n_tests++;
                if (wgt_w_en !== 1'b1 || wgt_w_buf !== 1'b0 || wgt_w_addr !== 2'd0 || wgt_data !== mk(10'h200)) begin
                    n_fail++; $display("FAIL b2b_wgt_write: got en=%0b buf=%0b addr=%0d expected 1/0/0", wgt_w_en, wgt_w_buf, wgt_w_addr);
                end
            end
            if (c == 16) begin
                n_tests++;
                if (actv_w_en !== 1'b1 || actv_w_buf !== 1'b1 || actv_w_addr !== 2'd0 || actv_data !== mk(10'h104)) begin
                    n_fail++; $display("FAIL b2b_actv2_write: got en=%0b buf=%0b addr=%0d expected 1/1/0", actv_w_en, actv_w_buf, actv_w_addr);
                end
            end
        end
        n_tests++;
        if (gbf_rd_en !== 1'b0 || busy !== 1'b0 || actv_data_avail !== 1'b1 || wgt_data_avail !== 1'b1) begin
            n_fail++; $display("FAIL b2b_end: got rd_en=%0b busy=%0b avail=%0b%0b expected 0/0/11", gbf_rd_en, busy, actv_data_avail, wgt_data_avail);
        end
        n_tests++;
`ifdef RF_FILL_PERF_CNT_EN
        if (stall_cnt !== 32'd24) begin
            n_fail++; $display("FAIL b2b_stall: got %0d expected 24", stall_cnt);
        end
`else
        if (stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL b2b_stall: got %0d expected 0", stall_cnt);
        end
`endif
    endtask

    // Offset and address wrap at the top of the 10-bit GBF space.
    task automatic test_offset_wrap();
        logic [9:0] got [8];
        int         n;
        do_reset();
        actv_base_addr = 10'h3FE;
        actv_rf1_need_data = 1'b1;
        n = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (gbf_rd_en === 1'b1 && n < 8) begin got[n] = gbf_rd_addr; n++; end
        end
        n_tests++;
        if (n != 4 || got[0] !== 10'h3FE || got[1] !== 10'h3FF || got[2] !== 10'h000 || got[3] !== 10'h001) begin
            n_fail++; $display("FAIL wrap_first: got n=%0d addr0=%0h addr3=%0h expected 4 3fe 001", n, got[0], got[3]);
        end
        actv_rf1_need_data = 1'b0;
        tick();
        actv_rf1_need_data = 1'b1;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (gbf_rd_en === 1'b1 && n < 8) begin got[n] = gbf_rd_addr; n++; end
        end
        n_tests++;
        if (n != 4 || got[0] !== 10'h002 || got[1] !== 10'h003 || got[2] !== 10'h004 || got[3] !== 10'h005) begin
            n_fail++; $display("FAIL wrap_second: got n=%0d addr0=%0h addr3=%0h expected 4 002 005", n, got[0], got[3]);
        end
    endtask

    // A held request is not re-served; a fresh rising edge re-arms it.
    task automatic test_hold_need();
        int rd_cnt;
        do_reset();
        actv_base_addr = 10'h100;
        actv_rf1_need_data = 1'b1;
        for (int c = 1; c <= 8; c++) tick();
        rd_cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (gbf_rd_en === 1'b1) rd_cnt++;
        end
        n_tests++;
        if (rd_cnt != 0 || actv_data_avail !== 1'b1) begin
            n_fail++; $display("FAIL hold_no_regrant: got rd_cycles=%0d avail=%0b expected 0/1", rd_cnt, actv_data_avail);
        end
        actv_rf1_need_data = 1'b0;
        tick();
        n_tests++;
        if (actv_data_avail !== 1'b1) begin
            n_fail++; $display("FAIL hold_fall_avail: got %0b expected 1", actv_data_avail);
        end
        actv_rf1_need_data = 1'b1;
        tick();
        n_tests++;
        if (actv_data_avail !== 1'b0 || gbf_rd_en !== 1'b1 || gbf_rd_addr !== 10'h104) begin
            n_fail++; $display("FAIL hold_rise: got avail=%0b rd_en=%0b addr=%0h expected 0/1/104", actv_data_avail, gbf_rd_en, gbf_rd_addr);
        end
    endtask

    // finish mid-burst lets the burst complete and then blocks grants.
    task automatic test_finish();
        int sf_cnt, sf_cyc, rd_late, other_sf;
        do_reset();
        actv_base_addr = 10'h100;
        wgt_base_addr  = 10'h200;
        actv_rf1_need_data = 1'b1;
        wgt_rf1_need_data  = 1'b1;
        tick();
        tick();
        finish = 1'b1;
        sf_cnt = 0; sf_cyc = 0; rd_late = 0; other_sf = 0;
        for (int c = 3; c <= 15; c++) begin
            tick();
            if (actv_buf1_send_finish === 1'b1) begin sf_cnt++; sf_cyc = c; end
            if (sf_vec()[3:1] !== 3'b000) other_sf++;
            if (c >= 6 && gbf_rd_en === 1'b1) rd_late++;
        end
        n_tests++;
        if (sf_cnt != 1 || sf_cyc != 6) begin
            n_fail++; $display("FAIL finish_pulse: got count=%0d cycle=%0d expected 1 at 6", sf_cnt, sf_cyc);
        end
        n_tests++;
        if (rd_late != 0 || other_sf != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL finish_block: got rd_cycles=%0d other_sf=%0d busy=%0b expected 0/0/0", rd_late, other_sf, busy);
        end
        finish = 1'b0;
        tick();
        n_tests++;
        if (gbf_rd_en !== 1'b1 || gbf_rd_addr !== 10'h200) begin
            n_fail++; $display("FAIL finish_release: got rd_en=%0b addr=%0h expected 1/200", gbf_rd_en, gbf_rd_addr);
        end
        finish = 1'b0;
    endtask

    // Reset mid-burst clears outputs at once and restarts from base+0.
    task automatic test_reset_mid_burst();
        int   sf_cnt;
        logic found;
        do_reset();
        actv_base_addr = 10'h100;
        actv_rf1_need_data = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        n_tests++;
        if (gbf_rd_en !== 1'b0 || gbf_rd_addr !== 10'h000 || actv_w_en !== 1'b0 || actv_w_addr !== 2'd0 ||
            actv_data !== '0 || busy !== 1'b0 || actv_data_avail !== 1'b0 || sf_vec() !== 4'b0000) begin
            n_fail++; $display("FAIL reset_mid_outputs: got rd_en=%0b addr=%0h w_en=%0b busy=%0b expected all 0", gbf_rd_en, gbf_rd_addr, actv_w_en, busy);
        end
        sf_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (sf_vec() !== 4'b0000) sf_cnt++;
        end
        reset = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            tick();
            if (sf_vec() !== 4'b0000) sf_cnt++;
            if (gbf_rd_en === 1'b1) found = 1'b1;
        end
        n_tests++;
        if (found !== 1'b1 || gbf_rd_addr !== 10'h100 || sf_cnt != 0) begin
            n_fail++; $display("FAIL reset_mid_restart: got found=%0b addr=%0h sf_pulses=%0d expected 1/100/0", found, gbf_rd_addr, sf_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_offset_wrap();
        test_hold_need();
        test_finish();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
